// File: rtl/wave_analyzer.sv
// wave_analyzer: receive-side measurement block for a DDS waveform.
// It recovers the DDS tuning word, the period and the peak amplitudes of a
// signed sampled waveform such as a sine, sawtooth or square wave.
//
// How a measurement works:
//   - A hysteresis zone tracker turns the samples into rising events
//     (zone LOW -> HIGH).
//   - The FSM waits in ARM for a rising event, which starts a measurement.
//   - It stays in MEASURE until 2^AVG_LOG2 more rising events have been seen.
//   - DIVIDE then runs a serial division to get 2^(32+AVG_LOG2) / total.
//   - DONE publishes the results for one clock.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset.
//   wave_in     : signed input sample; it is used only while wave_valid = 1.
//   wave_valid  : sample qualifier.
//   freq_word   : measured tuning word (2^32 = one cycle per sample).
//   period      : number of valid samples spanning 2^AVG_LOG2 periods.
//   peak_max    : signed maximum over the last measurement window.
//   peak_min    : signed minimum over the last measurement window.
//   meas_valid  : one-cycle pulse when the results update.
//   no_signal   : level; high after 2^TIMEOUT_LOG2 valid samples pass
//                 with no rising event.
//   busy        : high while in MEASURE or DIVIDE.
module wave_analyzer #(
  parameter int WAVE_WIDTH   = 16,
  parameter int HYST         = 256,
  parameter int AVG_LOG2     = 2,
  parameter int TIMEOUT_LOG2 = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [WAVE_WIDTH-1:0] wave_in,
  input  logic                         wave_valid,
  output logic [31:0]                  freq_word,
  output logic [31:0]                  period,
  output logic signed [WAVE_WIDTH-1:0] peak_max,
  output logic signed [WAVE_WIDTH-1:0] peak_min,
  output logic                         meas_valid,
  output logic                         no_signal,
  output logic                         busy
);

  localparam int DIV_STEPS = 33 + AVG_LOG2;
  localparam int DCW       = $clog2(DIV_STEPS);

  localparam logic signed [WAVE_WIDTH-1:0] HYST_POS = WAVE_WIDTH'(HYST);
  localparam logic signed [WAVE_WIDTH-1:0] HYST_NEG = WAVE_WIDTH'(-HYST);
  localparam logic [AVG_LOG2:0]            EDGE_N   = (AVG_LOG2+1)'(64'd1 << AVG_LOG2);
  localparam logic [TIMEOUT_LOG2:0]        TMO_LIM  = (TIMEOUT_LOG2+1)'(64'd1 << TIMEOUT_LOG2);
  localparam logic [DCW-1:0]               DIV_LAST = DCW'(DIV_STEPS - 1);

  typedef enum logic [1:0] {S_ARM, S_MEASURE, S_DIVIDE, S_DONE} state_t;
  typedef enum logic [1:0] {Z_UNKNOWN, Z_LOW, Z_HIGH} zone_t;

  state_t                        state_q;
  zone_t                         zone_q, zone_d;
  logic [31:0]                   freq_word_q, period_q;
  logic signed [WAVE_WIDTH-1:0]  peak_max_q, peak_min_q;
  logic signed [WAVE_WIDTH-1:0]  run_max_q, run_min_q;
  logic                          meas_valid_q, no_signal_q;
  logic [TIMEOUT_LOG2:0]         tmo_cnt_q;
  logic [AVG_LOG2:0]             edge_cnt_q;
  logic [31:0]                   span_q;
  logic [31:0]                   total_q;
  logic [31:0]                   rem_q, quo_q;
  logic [DCW-1:0]                div_cnt_q;

  logic                          sample_high, sample_low, rising, timeout;
  logic [TIMEOUT_LOG2:0]         tmo_inc;
  logic [AVG_LOG2:0]             edge_inc;
  logic [31:0]                   span_inc;
  logic [32:0]                   rem_shift;
  logic                          quo_bit;
  logic [31:0]                   rem_d;

  assign sample_high = wave_valid && (wave_in >= HYST_POS);
  assign sample_low  = wave_valid && (wave_in <= HYST_NEG);
  // A LOW -> HIGH move is an event; UNKNOWN -> HIGH is not.
  assign rising      = sample_high && (zone_q == Z_LOW);

  always_comb begin
    zone_d = zone_q;
    if (sample_high) begin
      zone_d = Z_HIGH;
    end else if (sample_low) begin
      zone_d = Z_LOW;
    end
  end

  assign tmo_inc  = tmo_cnt_q + 1'b1;
  assign edge_inc = edge_cnt_q + 1'b1;
  assign span_inc = span_q + 32'd1;
  // A rising event in the same sample takes priority over the timeout.
  assign timeout  = wave_valid && !rising && (tmo_inc == TMO_LIM);

  // Restoring division. The dividend 2^(32+AVG_LOG2) contributes a single
  // 1 bit, on the first step; every later step shifts in a zero. The
  // remainder always stays below total, so 32 bits are enough to hold it.
  assign rem_shift = {rem_q, (div_cnt_q == '0)};
  assign quo_bit   = (rem_shift >= {1'b0, total_q});
  assign rem_d     = quo_bit ? 32'(rem_shift - {1'b0, total_q}) : rem_shift[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ARM;
      zone_q       <= Z_UNKNOWN;
      freq_word_q  <= '0;
      period_q     <= '0;
      peak_max_q   <= '0;
      peak_min_q   <= '0;
      run_max_q    <= '0;
      run_min_q    <= '0;
      meas_valid_q <= 1'b0;
      no_signal_q  <= 1'b0;
      tmo_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      span_q       <= '0;
      total_q      <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_cnt_q    <= '0;
    end else begin
      meas_valid_q <= 1'b0;
      zone_q       <= zone_d;
      case (state_q)
        S_ARM, S_MEASURE: begin
          if (timeout) begin
            // The signal was lost: abandon any partial measurement.
            tmo_cnt_q   <= '0;
            no_signal_q <= 1'b1;
            freq_word_q <= '0;
            period_q    <= '0;
            state_q     <= S_ARM;
          end else if (wave_valid) begin
            if (rising) begin
              tmo_cnt_q <= '0;
            end else begin
              tmo_cnt_q <= tmo_inc;
            end
            if (state_q == S_ARM) begin
              if (rising) begin
                span_q     <= '0;
                edge_cnt_q <= '0;
                run_max_q  <= wave_in;
                run_min_q  <= wave_in;
                state_q    <= S_MEASURE;
              end
            end else begin
              // span_q counts valid samples since the start sample.
              span_q <= span_inc;
              if (wave_in > run_max_q) begin
                run_max_q <= wave_in;
              end
              if (wave_in < run_min_q) begin
                run_min_q <= wave_in;
              end
              if (rising) begin
                edge_cnt_q <= edge_inc;
                if (edge_inc == EDGE_N) begin
                  total_q   <= span_inc;
                  rem_q     <= '0;
                  quo_q     <= '0;
                  div_cnt_q <= '0;
                  state_q   <= S_DIVIDE;
                end
              end
            end
          end
        end
        S_DIVIDE: begin
          rem_q     <= rem_d;
          quo_q     <= {quo_q[30:0], quo_bit};
          div_cnt_q <= div_cnt_q + 1'b1;
          if (div_cnt_q == DIV_LAST) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          freq_word_q  <= quo_q;
          period_q     <= total_q;
          peak_max_q   <= run_max_q;
          peak_min_q   <= run_min_q;
          meas_valid_q <= 1'b1;
          no_signal_q  <= 1'b0;
          tmo_cnt_q    <= '0;
          state_q      <= S_ARM;
        end
        default: state_q <= S_ARM;
      endcase
    end
  end

  assign freq_word  = freq_word_q;
  assign period     = period_q;
  assign peak_max   = peak_max_q;
  assign peak_min   = peak_min_q;
  assign meas_valid = meas_valid_q;
  assign no_signal  = no_signal_q;
  assign busy       = (state_q == S_MEASURE) || (state_q == S_DIVIDE);

endmodule

// File: tb/tb_wave_analyzer.sv
// Testbench for wave_analyzer.
// A behavioural model works from valid-sample indices, the e - s span and a
// plain integer division. It predicts every output after each clock, and the
// DUT is compared against that prediction on every falling edge. Directed
// scenarios add literal expectations that pin down the model itself.
module tb_wave_analyzer;
  localparam int WW    = 16;
  localparam int HYST  = 256;
  localparam int AL    = 2;
  localparam int TL    = 10;
  localparam int NEDGE = 1 << AL;
  localparam int LAT   = 34 + AL;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [WW-1:0] wave_in = '0;
  logic                 wave_valid = 1'b0;
  logic [31:0]          freq_word, period;
  logic signed [WW-1:0] peak_max, peak_min;
  logic                 meas_valid, no_signal, busy;

  wave_analyzer #(
    .WAVE_WIDTH(WW), .HYST(HYST), .AVG_LOG2(AL), .TIMEOUT_LOG2(TL)
  ) dut (
    .clk(clk), .rst(rst), .wave_in(wave_in), .wave_valid(wave_valid),
    .freq_word(freq_word), .period(period), .peak_max(peak_max),
    .peak_min(peak_min), .meas_valid(meas_valid), .no_signal(no_signal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  bit     model_live = 1'b0;

  // Model state and expected outputs.
  int     m_zone, m_phase, m_tcnt, m_edges, m_max, m_min;
  longint m_idx, m_start, m_total, m_q, m_due;
  longint exp_freq, exp_period;
  int     exp_max, exp_min;
  bit     exp_mv, exp_ns, exp_busy;

  // Things observed on the DUT, for the directed checks.
  int     mv_count = 0;
  longint last_mv_cyc = 0, ns_rise_cyc = 0, c0 = 0;
  longint last_freq = 0, last_period = 0;
  int     last_max = 0, last_min = 0;
  bit     ns_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  // Behavioural model. Phases: 0 = waiting for an edge, 1 = measuring,
  // 2 = result pending, due at cycle m_due.
  always @(posedge clk) begin
    bit rise;
    int s;
    cyc++;
    model_live = 1'b1;
    exp_mv = 1'b0;
    if (rst) begin
      m_zone = 0; m_phase = 0; m_tcnt = 0; m_idx = 0;
      exp_freq = 0; exp_period = 0; exp_max = 0; exp_min = 0; exp_ns = 1'b0;
    end else begin
      s = int'(wave_in);
      rise = 1'b0;
      if (wave_valid) begin
        rise = (m_zone == 1) && (s >= HYST);
        if (s >= HYST) m_zone = 2;
        else if (s <= -HYST) m_zone = 1;
      end
      if (m_phase == 2) begin
        if (cyc == m_due) begin
          exp_freq = m_q; exp_period = m_total; exp_max = m_max; exp_min = m_min;
          exp_mv = 1'b1; exp_ns = 1'b0; m_phase = 0; m_tcnt = 0;
        end
      end else if (wave_valid) begin
        if (rise) m_tcnt = 0; else m_tcnt++;
        if (m_tcnt == (1 << TL)) begin
          exp_ns = 1'b1; exp_freq = 0; exp_period = 0; m_phase = 0; m_tcnt = 0;
        end else if (m_phase == 0) begin
          if (rise) begin
            m_start = m_idx; m_edges = 0; m_max = s; m_min = s; m_phase = 1;
          end
        end else begin
          if (s > m_max) m_max = s;
          if (s < m_min) m_min = s;
          if (rise) begin
            m_edges++;
            if (m_edges == NEDGE) begin
              m_total = m_idx - m_start;
              m_q = (longint'(1) << (32 + AL)) / m_total;
              m_due = cyc + LAT;
              m_phase = 2;
            end
          end
        end
      end
      if (wave_valid) m_idx++;
    end
    exp_busy = (m_phase == 1) || (m_phase == 2 && cyc < m_due - 1);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("meas_valid", meas_valid, exp_mv);
      check("no_signal", no_signal, exp_ns);
      check("busy", busy, exp_busy);
      check("freq_word", freq_word, exp_freq);
      check("period", period, exp_period);
      check("peak_max", 64'(peak_max), exp_max);
      check("peak_min", 64'(peak_min), exp_min);
      if (meas_valid === 1'b1) begin
        mv_count++;
        last_mv_cyc = cyc;
        last_freq = freq_word;
        last_period = period;
        last_max = peak_max;
        last_min = peak_min;
      end
      if (no_signal === 1'b1 && !ns_prev) ns_rise_cyc = cyc;
      ns_prev = (no_signal === 1'b1);
    end
  end

  task automatic drive(input bit v, input int s);
    @(negedge clk);
    wave_valid = v;
    wave_in = WW'(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wave_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Square wave: +16383 for 50 samples, then -16383 for 50. c0 is the
  // clock that consumes sample 0.
  task automatic square(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) drive(1'b0, 0);
      drive(1'b1, ((i % 100) < 50) ? 16383 : -16383);
      if (i == 0) c0 = cyc + 1;
    end
  endtask

  initial begin
    int base;
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Values after reset.
    check("rst_freq", freq_word, 0);
    check("rst_period", period, 0);
    check("rst_peak_max", 64'(peak_max), 0);
    check("rst_mv", meas_valid, 0);
    check("rst_ns", no_signal, 0);
    check("rst_busy", busy, 0);

    // Continuous square wave.
    base = mv_count;
    square(600, 1'b0);
    check("sq_mv_count", mv_count - base, 1);
    check("sq_mv_cycle", last_mv_cyc, c0 + 500 + LAT);
    check("sq_freq", last_freq, 42949672);
    check("sq_period", last_period, 400);
    check("sq_peak_max", last_max, 16383);
    check("sq_peak_min", last_min, -16383);

    // Square wave with wave_valid low on every other clock.
    do_reset();
    base = mv_count;
    square(560, 1'b1);
    check("gap_mv_count", mv_count - base, 1);
    check("gap_mv_cycle", last_mv_cyc, c0 + 1000 + LAT);
    check("gap_freq", last_freq, 42949672);
    check("gap_period", last_period, 400);

    // Noise inside the hysteresis band.
    do_reset();
    base = mv_count;
    for (int i = 0; i < 2000; i++) drive(1'b1, int'($urandom_range(400)) - 200);
    drive(1'b0, 0);
    drive(1'b0, 0);
    check("noise_mv_count", mv_count - base, 0);
    check("noise_freq", freq_word, 0);
    check("noise_ns", no_signal, 1);

    // Timeout after the last rising event, then recovery.
    do_reset();
    base = mv_count;
    square(700, 1'b0);
    for (int i = 0; i < 1100; i++) drive(1'b1, 0);
    check("tmo_ns_cycle", ns_rise_cyc, c0 + 600 + 1024);
    check("tmo_ns", no_signal, 1);
    check("tmo_freq", freq_word, 0);
    check("tmo_mv_count", mv_count - base, 1);
    base = mv_count;
    square(700, 1'b0);
    check("resume_mv_count", mv_count - base, 1);
    check("resume_ns", no_signal, 0);
    check("resume_freq", freq_word, 42949672);

    // Reset while the divider is running.
    do_reset();
    square(1005, 1'b0);
    check("div_busy_before", busy, 1);
    check("div_freq_before", freq_word, 42949672);
    base = mv_count;
    @(negedge clk);
    rst = 1'b1;
    wave_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("divrst_freq", freq_word, 0);
    check("divrst_period", period, 0);
    check("divrst_peak_min", 64'(peak_min), 0);
    check("divrst_busy", busy, 0);
    repeat (60) drive(1'b0, 0);
    check("divrst_no_mv", mv_count - base, 0);
    square(700, 1'b0);
    check("divrst_after_mv", mv_count - base, 1);
    check("divrst_after_freq", last_freq, 42949672);

    // Randomized sine and square segments, checked against the model only.
    for (int seg = 0; seg < 8; seg++) begin
      int     vp, amp, half, k, s;
      bit     sine;
      bit [31:0] acc, inc;
      vp = (seg % 3 == 0) ? 100 : int'($urandom_range(40, 95));
      amp = int'($urandom_range(300, 32767));
      sine = (seg % 2 == 0);
      inc = $urandom_range(14316557, 143165576);
      half = int'($urandom_range(1, 60));
      acc = $urandom;
      k = 0;
      if ($urandom_range(3) == 0) do_reset();
      for (int c = 0; c < 2500; c++) begin
        if (sine) s = $rtoi(real'(amp) * $sin(6.283185307179586 * real'(acc) / 4294967296.0));
        else s = ((k / half) % 2 == 0) ? amp : -amp;
        if (int'($urandom_range(99)) < vp) begin
          drive(1'b1, s);
          acc = acc + inc;
          k++;
        end else begin
          drive(1'b0, int'($urandom_range(1000)));
        end
      end
    end
    drive(1'b0, 0);
    drive(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
